rdb_rd_sched: RTL and testbench
===============================

// Module: rdb_rd_sched
// PURPOSE
//  Round-robin scheduler that shares the single dataram read port between REQ_NUM requesters.
//  Requesters: hit-read, linefill-forward, evict-read.
//  Each granted read gets a free read-data-buffer (RDB) entry; the entry id goes in out_pld.db_entry_id.
//  The entry is held busy until the US-side release (to_us_done) frees it.
//  Sits between the request pipes and the RDB agent's dataram_rd_vld/pld/rdy input.
// PARAMETERS
//  REQ_NUM        3                   number of requesters (>=2)
//  ENTRY_NUM      RW_DB_ENTRY_NUM     RDB entries tracked (>=2)
//  ENTRY_W        DB_ENTRY_IDX_WIDTH  entry id width, $clog2(ENTRY_NUM)
// PORTS
//  clk           in   1                      clock
//  rst_n         in   1                      async active-low reset
//  req_vld       in   REQ_NUM                per-requester read request
//  req_pld       in   REQ_NUM x arb_out_req_t  payload; db_entry_id field ignored on input
//  req_rdy       out  REQ_NUM                one-hot accept
//  out_vld       out  1                      registered request to dataram/RDB agent
//  out_pld       out  arb_out_req_t          granted payload, db_entry_id = allocated entry
//  out_rdy       in   1                      downstream accept (dataram_rd_rdy)
//  rel_vld       in   1                      RDB entry release (to_us_done)
//  rel_idx       in   ENTRY_W                entry being released
//  free_cnt      out  ENTRY_W+1              free RDB entries (registered)
//  rel_err       out  1                      sticky: release of a non-busy entry
// BEHAVIOUR
//  Reset values: busy vec=0, free_cnt=ENTRY_NUM, rr_ptr=0, out_vld=0, out_pld=0, rel_err=0.
//  Output stage is a 1-deep pipe register.
//   - can_load = ~out_vld | out_rdy.
//   - Grant is issued only when can_load && any req_vld && free_cnt!=0.
//   - Latency: req accepted at cycle N -> out_vld=1 at N+1.
//   - Out holds stable (vld/pld) until out_rdy.
//  Arbitration is round-robin.
//   - Search starts at rr_ptr and wraps REQ_NUM-1 -> 0.
//   - On accept, rr_ptr <= granted+1 (mod REQ_NUM).
//   - rr_ptr holds when no accept.
//   - req_rdy is one-hot or all-0, and is combinational from req_vld/state.
//  Allocation: lowest-index clear bit of busy vec, sampled pre-update; busy[alloc] <= 1 on accept.
//  Release: rel_vld && busy[rel_idx] -> busy[rel_idx] <= 0.
//   - rel_vld && ~busy[rel_idx] -> no state change, rel_err <= 1 (sticky until reset).
//   - rel_idx >= ENTRY_NUM is treated as an error the same way.
//  Same-cycle alloc+release: both apply.
//   - A released entry becomes allocatable the next cycle (no same-cycle bypass).
//   - free_cnt += rel_ok - alloc, i.e. it holds when both occur.
//  Full: free_cnt==0 -> req_rdy=0 for all; pending out reg still drains.
//  free_cnt never exceeds ENTRY_NUM or underflows; it always equals popcount(~busy).
//  Reset mid-operation clears all in-flight state; requesters re-issue.
// STRUCTURE
//  vector_cache_pkg gets RDB_SCHED_REQ_NUM; it reuses arb_out_req_t and DB_ENTRY_IDX_WIDTH.
//  One sub-module, rr_arb_ptr (REQ_NUM-wide round-robin grant with pointer update).
//  The entry pick is a find-first-zero function local to the block.
// TESTING  (REQ_NUM=3, ENTRY_NUM=4)
//  1. Single req0 with out_rdy=1 -> out_vld next cycle, db_entry_id=0, free_cnt 4->3.
//  2. req0..2 held continuously, out_rdy=1 -> grants 0,1,2,0; entries 0,1,2,3; then req_rdy=0 with free_cnt=0.
//  3. Full, then rel_idx=2 -> next-cycle grant gets entry 2 and free_cnt returns to 0.
//     Same-cycle rel(1)+alloc -> free_cnt unchanged.
//  4. out_rdy=0 for 5 cycles with out_vld=1 -> out_pld stable, req_rdy=0, rr_ptr unchanged.
//  5. rel_idx=3 when entry 3 is free -> rel_err=1 and stays 1; busy/free_cnt unchanged.
//  6. Assert rst_n mid-burst (2 entries busy) -> out_vld=0, free_cnt=4, next grant gets req0 and entry 0.

Source files
------------

// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: the arbitrated dataram read request and RDB sizing.
// The read scheduler takes its requester count and entry geometry from here.
package vector_cache_pkg;

  localparam int RW_DB_ENTRY_NUM    = 4;
  localparam int DB_ENTRY_IDX_WIDTH = $clog2(RW_DB_ENTRY_NUM);
  localparam int RDB_SCHED_REQ_NUM  = 3;

  localparam int VC_ADDR_W   = 8;
  localparam int VC_WAY_W    = 2;
  localparam int VC_TXN_ID_W = 4;

  // Requester slot order on the scheduler's req_* vectors
  typedef enum logic [1:0] {
    RDB_REQ_HIT   = 2'd0,
    RDB_REQ_LFWD  = 2'd1,
    RDB_REQ_EVICT = 2'd2
  } rdb_req_src_e;

  typedef struct packed {
    logic [VC_TXN_ID_W-1:0]        txn_id;
    logic [VC_ADDR_W-1:0]          addr;
    logic [VC_WAY_W-1:0]           way;
    logic [DB_ENTRY_IDX_WIDTH-1:0] db_entry_id;
  } arb_out_req_t;

endpackage

// File: rtl/rdb_rd_sched_rr_arb_ptr.sv
// Round-robin grant over N requesters: the search starts at the pointer and wraps,
// and the pointer advances past the winner only when the grant is actually taken.
module rr_arb_ptr #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          acc,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] ptr;

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (acc) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rdb_rd_sched.sv
// Shares the dataram read port among the read requesters and tags every granted read
// with a free RDB entry, which stays busy until the upstream side releases it.
module rdb_rd_sched
  import vector_cache_pkg::*;
#(
  parameter int REQ_NUM   = RDB_SCHED_REQ_NUM,
  parameter int ENTRY_NUM = RW_DB_ENTRY_NUM,
  parameter int ENTRY_W   = DB_ENTRY_IDX_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [REQ_NUM-1:0]         req_vld,
  input  arb_out_req_t [REQ_NUM-1:0] req_pld,
  output logic [REQ_NUM-1:0]         req_rdy,
  output logic                       out_vld,
  output arb_out_req_t               out_pld,
  input  logic                       out_rdy,
  input  logic                       rel_vld,
  input  logic [ENTRY_W-1:0]         rel_idx,
  output logic [ENTRY_W:0]           free_cnt,
  output logic                       rel_err
);

  localparam int PW     = $clog2(REQ_NUM);
  localparam int FREE_W = ENTRY_W + 1;

  // Handshake: a transfer happens on a cycle where vld && rdy; vld and payload hold
  // unchanged until then, and rdy never depends on the same port's payload.

  logic [ENTRY_NUM-1:0] busy;
  logic [ENTRY_NUM-1:0] busy_nxt;
  logic [FREE_W-1:0]    free_cnt_nxt;
  logic [REQ_NUM-1:0]   gnt;
  logic [PW-1:0]        gnt_idx;
  logic [ENTRY_W-1:0]   alloc_idx;
  logic                 can_load;
  logic                 grant_en;
  logic                 accept;
  logic                 rel_in_range;
  logic                 rel_ok;
  arb_out_req_t         sel_pld;

  function automatic logic [ENTRY_W-1:0] find_first_zero(input logic [ENTRY_NUM-1:0] vec);
    find_first_zero = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!vec[i]) find_first_zero = ENTRY_W'(i);
    end
  endfunction

  rr_arb_ptr #(.N(REQ_NUM), .PW(PW)) u_rr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_vld),
    .acc     (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign can_load  = ~out_vld | out_rdy;
  assign grant_en  = can_load && (free_cnt != '0);
  assign req_rdy   = grant_en ? gnt : '0;
  assign accept    = |req_rdy;
  // Sampled from the registered busy vector, so a same-cycle release is not visible yet
  assign alloc_idx = find_first_zero(busy);

  assign rel_in_range = int'(rel_idx) < ENTRY_NUM;
  assign rel_ok       = rel_vld && rel_in_range && busy[rel_idx];

  always_comb begin
    sel_pld             = req_pld[gnt_idx];
    sel_pld.db_entry_id = alloc_idx;
  end

  // Alloc targets a clear bit and release a set bit, so the two never collide
  always_comb begin
    busy_nxt = busy;
    if (accept) busy_nxt[alloc_idx] = 1'b1;
    if (rel_ok) busy_nxt[rel_idx]   = 1'b0;
  end

  always_comb begin
    free_cnt_nxt = free_cnt;
    case ({accept, rel_ok})
      2'b10:   free_cnt_nxt = free_cnt - 1'b1;
      2'b01:   free_cnt_nxt = free_cnt + 1'b1;
      default: free_cnt_nxt = free_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      free_cnt <= FREE_W'(ENTRY_NUM);
      out_vld  <= 1'b0;
      out_pld  <= '0;
      rel_err  <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      free_cnt <= free_cnt_nxt;
      if (rel_vld && !rel_ok) rel_err <= 1'b1;
      if (can_load) begin
        out_vld <= accept;
        if (accept) out_pld <= sel_pld;
      end
    end
  end

endmodule

// File: tb/tb_rdb_rd_sched.sv
// Directed bench for rdb_rd_sched (3 requesters, 4 RDB entries) with an output scoreboard.
module tb_rdb_rd_sched;
  import vector_cache_pkg::*;

  localparam int PLD_W = $bits(arb_out_req_t);

  logic               clk;
  logic               rst_n;
  logic [2:0]         req_vld;
  arb_out_req_t [2:0] req_pld;
  logic [2:0]         req_rdy;
  logic               out_vld;
  arb_out_req_t       out_pld;
  logic               out_rdy;
  logic               rel_vld;
  logic [1:0]         rel_idx;
  logic [2:0]         free_cnt;
  logic               rel_err;

  logic [PLD_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  rdb_rd_sched #(.REQ_NUM(3), .ENTRY_NUM(4), .ENTRY_W(2)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_pld  (req_pld),
    .req_rdy  (req_rdy),
    .out_vld  (out_vld),
    .out_pld  (out_pld),
    .out_rdy  (out_rdy),
    .rel_vld  (rel_vld),
    .rel_idx  (rel_idx),
    .free_cnt (free_cnt),
    .rel_err  (rel_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_dut();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // driver tasks
  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic rand_plds();
    for (int i = 0; i < 3; i++) begin
      req_pld[i].txn_id      = VC_TXN_ID_W'($urandom_range(0, 15));
      req_pld[i].addr        = VC_ADDR_W'($urandom_range(0, 255));
      req_pld[i].way         = VC_WAY_W'(i);
      req_pld[i].db_entry_id = DB_ENTRY_IDX_WIDTH'($urandom_range(0, 3));
    end
  endtask

  function automatic logic [PLD_W-1:0] exp_pld(int g, int e);
    arb_out_req_t p;
    p             = req_pld[g];
    p.db_entry_id = DB_ENTRY_IDX_WIDTH'(e);
    return p;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every delivered output must match the oldest expected grant
  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      check("out_q_level", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [PLD_W-1:0] e;
        e = exp_q.pop_front();
        check("out_pld", 32'(out_pld), 32'(e));
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    req_vld = '0;
    out_rdy = 1'b1;
    rel_vld = 1'b0;
    rel_idx = '0;
    rand_plds();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    smp();
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out_pld", 32'(out_pld), 32'd0);
    check("rst_free_cnt", 32'(free_cnt), 32'd4);
    check("rst_rel_err", 32'(rel_err), 32'd0);
    check("rst_req_rdy", 32'(req_rdy), 32'd0);

    // 1: single request, one-cycle latency, entry 0
    drv(); req_vld = 3'b001;
    smp(); check("t1_req_rdy", 32'(req_rdy), 32'b001); exp_q.push_back(exp_pld(0, 0));
    drv(); req_vld = 3'b000;
    smp(); check("t1_out_vld", 32'(out_vld), 32'd1); check("t1_free_cnt", 32'(free_cnt), 32'd3);
    drv(); rel_vld = 1'b1; rel_idx = 2'd0;
    drv(); rel_vld = 1'b0;
    smp(); check("t1_rel_free", 32'(free_cnt), 32'd4); check("t1_rel_err", 32'(rel_err), 32'd0);

    // 2: three requesters held, round-robin until full
    reset_dut();
    rand_plds();
    req_vld = 3'b111;
    for (int k = 0; k < 4; k++) begin
      smp();
      check("t2_req_rdy", 32'(req_rdy), 32'(1 << (k % 3)));
      check("t2_free_cnt", 32'(free_cnt), 32'(4 - k));
      exp_q.push_back(exp_pld(k % 3, k));
      drv();
    end
    smp();
    check("t2_full_rdy", 32'(req_rdy), 32'd0);
    check("t2_full_cnt", 32'(free_cnt), 32'd0);
    check("t2_drain_vld", 32'(out_vld), 32'd1);

    // 3: release while full, no same-cycle bypass; then alloc+release together
    drv(); rel_vld = 1'b1; rel_idx = 2'd2;
    smp(); check("t3_nobypass_rdy", 32'(req_rdy), 32'd0); check("t3_nobypass_cnt", 32'(free_cnt), 32'd0);
    drv(); rel_vld = 1'b0;
    smp(); check("t3_rel_cnt", 32'(free_cnt), 32'd1); check("t3_rel_rdy", 32'(req_rdy), 32'b010);
    exp_q.push_back(exp_pld(1, 2));
    drv();
    smp(); check("t3_refull_cnt", 32'(free_cnt), 32'd0); check("t3_refull_rdy", 32'(req_rdy), 32'd0);
    drv(); rel_vld = 1'b1; rel_idx = 2'd0;
    smp(); check("t3_rel0_rdy", 32'(req_rdy), 32'd0);
    drv(); rel_idx = 2'd1;
    smp(); check("t3_both_rdy", 32'(req_rdy), 32'b100); check("t3_both_pre", 32'(free_cnt), 32'd1);
    exp_q.push_back(exp_pld(2, 0));
    drv(); rel_vld = 1'b0; req_vld = 3'b000;
    smp(); check("t3_both_cnt", 32'(free_cnt), 32'd1);

    // 4: downstream stall holds output, blocks grants, keeps the pointer
    drv(); rel_vld = 1'b1; rel_idx = 2'd2;
    drv(); rel_idx = 2'd3;
    drv(); rel_vld = 1'b0;
    smp(); check("t4_free_pre", 32'(free_cnt), 32'd3);
    rand_plds();
    drv(); req_vld = 3'b010; out_rdy = 1'b0;
    smp(); check("t4_req_rdy", 32'(req_rdy), 32'b010); exp_q.push_back(exp_pld(1, 1));
    drv(); req_vld = 3'b111;
    for (int k = 0; k < 5; k++) begin
      smp();
      check("t4_stall_vld", 32'(out_vld), 32'd1);
      check("t4_stall_pld", 32'(out_pld), 32'(exp_q[0]));
      check("t4_stall_rdy", 32'(req_rdy), 32'd0);
      check("t4_stall_cnt", 32'(free_cnt), 32'd2);
      drv();
    end
    out_rdy = 1'b1;
    smp(); check("t4_resume_rdy", 32'(req_rdy), 32'b100); exp_q.push_back(exp_pld(2, 2));
    drv(); req_vld = 3'b000;
    smp(); check("t4_resume_vld", 32'(out_vld), 32'd1); check("t4_resume_cnt", 32'(free_cnt), 32'd1);

    // 5: release of a free entry is flagged, sticky, and changes nothing
    drv(); rel_vld = 1'b1; rel_idx = 2'd3;
    drv(); rel_vld = 1'b0;
    smp(); check("t5_rel_err", 32'(rel_err), 32'd1); check("t5_free_cnt", 32'(free_cnt), 32'd1);
    drv(); drv();
    smp(); check("t5_sticky", 32'(rel_err), 32'd1);
    drv(); req_vld = 3'b001;
    smp(); check("t5_req_rdy", 32'(req_rdy), 32'b001); check("t5_pre_cnt", 32'(free_cnt), 32'd1);
    exp_q.push_back(exp_pld(0, 3));
    drv(); req_vld = 3'b000;
    smp(); check("t5_full_cnt", 32'(free_cnt), 32'd0); check("t5_out_vld", 32'(out_vld), 32'd1);

    // 6: reset in the middle of a burst
    drv();
    reset_dut();
    rand_plds();
    req_vld = 3'b111;
    smp(); check("t6_rdy0", 32'(req_rdy), 32'b001); check("t6_cnt0", 32'(free_cnt), 32'd4);
    exp_q.push_back(exp_pld(0, 0));
    drv();
    smp(); check("t6_rdy1", 32'(req_rdy), 32'b010); check("t6_cnt1", 32'(free_cnt), 32'd3);
    exp_q.push_back(exp_pld(1, 1));
    drv();
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check("t6_rst_vld", 32'(out_vld), 32'd0);
    check("t6_rst_cnt", 32'(free_cnt), 32'd4);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    smp(); check("t6_post_rdy", 32'(req_rdy), 32'b001); check("t6_post_cnt", 32'(free_cnt), 32'd4);
    exp_q.push_back(exp_pld(0, 0));
    drv(); req_vld = 3'b000;
    smp(); check("t6_post_vld", 32'(out_vld), 32'd1); check("t6_post_cnt1", 32'(free_cnt), 32'd3);

    drv();
    smp(); check("final_q_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
